round_sequencer: RTL

- Top-level game controller that sequences per-frame player updates and round/match flow.
- Turns the display frame clock into one compute/commit pulse pair per frame for both player_next_state_calc instances.
- Gates button input by game phase, resolves hits (including trades), counts round wins and declares the match winner.
- Sits between the VGA frame timing, the hit-detection logic and the two player state blocks.

---
 rtl/round_sequencer_pkg.sv | 33 +++
 rtl/round_sequencer_frame_tick_sync.sv | 22 ++
 rtl/round_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/round_sequencer_pkg.sv
// Shared encodings and defaults for the round/match sequencer.
// Phase and result codes are exported on ports and must stay stable.
package round_sequencer_pkg;

  localparam logic [2:0] IDLE_PH      = 3'd0;
  localparam logic [2:0] COUNTDOWN_PH = 3'd1;
  localparam logic [2:0] FIGHT_PH     = 3'd2;
  localparam logic [2:0] ROUND_END_PH = 3'd3;
  localparam logic [2:0] MATCH_END_PH = 3'd4;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_P1   = 2'd1;
  localparam logic [1:0] RES_P2   = 2'd2;
  localparam logic [1:0] RES_DRAW = 2'd3;

  localparam logic [2:0] SEQ_WAIT    = 3'd0;
  localparam logic [2:0] SEQ_CALC    = 3'd1;
  localparam logic [2:0] SEQ_HOLD    = 3'd2;
  localparam logic [2:0] SEQ_RESOLVE = 3'd3;
  localparam logic [2:0] SEQ_COMMIT  = 3'd4;

  localparam int unsigned DEF_COUNTDOWN_FRAMES = 180;
  localparam int unsigned DEF_ROUND_FRAMES     = 5400;
  localparam int unsigned DEF_END_FRAMES       = 120;
  localparam int unsigned DEF_WINS_TO_MATCH    = 2;
  localparam int unsigned DEF_CALC_LATENCY     = 2;
  localparam int unsigned DEF_TIMER_W          = 13;

  function automatic logic [1:0] sat_inc(input logic [1:0] value);
    return (value == 2'd3) ? value : value + 2'd1;
  endfunction

endpackage

// File: rtl/round_sequencer_frame_tick_sync.sv
// Brings the display frame clock into sys_clk and emits a one-cycle pulse
// per rising edge, three sys_clk cycles after that edge.
module frame_tick_sync (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic [2:0] sync;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync       <= '0;
      frame_tick <= 1'b0;
    end else begin
      sync       <= {sync[1:0], frame_clk};
      frame_tick <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Game controller: one calc/commit pulse pair per frame, hit resolution,
// round win counting and match winner declaration.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
  parameter int unsigned ROUND_FRAMES     = DEF_ROUND_FRAMES,
  parameter int unsigned END_FRAMES       = DEF_END_FRAMES,
  parameter int unsigned WINS_TO_MATCH    = DEF_WINS_TO_MATCH,
  parameter int unsigned CALC_LATENCY     = DEF_CALC_LATENCY,
  parameter int unsigned TIMER_W          = DEF_TIMER_W
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               frame_clk,
  input  logic               start_btn,
  input  logic               p1_attack_connected,
  input  logic               p2_attack_connected,
  output logic               calc_en,
  output logic               commit_en,
  output logic               player_reset,
  output logic               buttons_enable,
  output logic [2:0]         game_phase,
  output logic [TIMER_W-1:0] frames_left,
  output logic [1:0]         p1_wins,
  output logic [1:0]         p2_wins,
  output logic [1:0]         round_result,
  output logic [1:0]         match_winner
);

  localparam int unsigned HOLD_CYC = (CALC_LATENCY > 0) ? CALC_LATENCY - 1 : 0;
  localparam int unsigned HOLD_W   = $clog2(HOLD_CYC + 2);

  logic [1:0]        rst_pipe;
  logic              rst_n;
  logic              frame_tick;
  logic [2:0]        seq;
  logic [HOLD_W-1:0] hold_cnt;
  logic              running;
  logic              resolve;
  logic              start_match;
  logic              timer_expired;

  // Async assert, sync deassert of the internal reset.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  frame_tick_sync u_tick (
    .sys_clk    (sys_clk),
    .reset_n    (rst_n),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  assign running        = (game_phase != IDLE_PH) && (game_phase != MATCH_END_PH);
  assign resolve        = (seq == SEQ_RESOLVE);
  assign calc_en        = (seq == SEQ_CALC);
  assign commit_en      = (seq == SEQ_COMMIT);
  assign buttons_enable = (game_phase == FIGHT_PH);
  assign start_match    = start_btn && !running;
  assign timer_expired  = (frames_left <= TIMER_W'(1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= SEQ_WAIT;
      hold_cnt <= '0;
    end else begin
      case (seq)
        SEQ_WAIT:    if (frame_tick && running) seq <= SEQ_CALC;
        SEQ_CALC: begin
          hold_cnt <= HOLD_W'(1);
          seq      <= (HOLD_CYC == 0) ? SEQ_RESOLVE : SEQ_HOLD;
        end
        SEQ_HOLD: begin
          if (hold_cnt >= HOLD_W'(HOLD_CYC)) seq <= SEQ_RESOLVE;
          else hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        SEQ_RESOLVE: seq <= SEQ_COMMIT;
        SEQ_COMMIT:  seq <= SEQ_WAIT;
        default:     seq <= SEQ_WAIT;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      game_phase   <= IDLE_PH;
      frames_left  <= '0;
      p1_wins      <= '0;
      p2_wins      <= '0;
      round_result <= RES_NONE;
      match_winner <= RES_NONE;
      player_reset <= 1'b0;
    end else begin
      player_reset <= 1'b0;
      if (start_match) begin
        game_phase   <= COUNTDOWN_PH;
        frames_left  <= TIMER_W'(COUNTDOWN_FRAMES);
        p1_wins      <= '0;
        p2_wins      <= '0;
        round_result <= RES_NONE;
        match_winner <= RES_NONE;
        player_reset <= 1'b1;
      end else if (resolve) begin
        case (game_phase)
          COUNTDOWN_PH: begin
            if (timer_expired) begin
              game_phase  <= FIGHT_PH;
              frames_left <= TIMER_W'(ROUND_FRAMES);
            end else begin
              frames_left <= frames_left - TIMER_W'(1);
            end
          end
          FIGHT_PH: begin
            // Hits take priority over timeout on the last frame of the round.
            if (p1_attack_connected || p2_attack_connected || timer_expired) begin
              game_phase  <= ROUND_END_PH;
              frames_left <= TIMER_W'(END_FRAMES);
              if (p1_attack_connected && !p2_attack_connected) begin
                round_result <= RES_P1;
                p1_wins      <= sat_inc(p1_wins);
              end else if (p2_attack_connected && !p1_attack_connected) begin
                round_result <= RES_P2;
                p2_wins      <= sat_inc(p2_wins);
              end else begin
                round_result <= RES_DRAW;
              end
            end else begin
              frames_left <= frames_left - TIMER_W'(1);
            end
          end
          ROUND_END_PH: begin
            if (!timer_expired) begin
              frames_left <= frames_left - TIMER_W'(1);
            end else if (p1_wins == 2'(WINS_TO_MATCH)) begin
              game_phase   <= MATCH_END_PH;
              frames_left  <= '0;
              match_winner <= RES_P1;
            end else if (p2_wins == 2'(WINS_TO_MATCH)) begin
              game_phase   <= MATCH_END_PH;
              frames_left  <= '0;
              match_winner <= RES_P2;
            end else begin
              game_phase   <= COUNTDOWN_PH;
              frames_left  <= TIMER_W'(COUNTDOWN_FRAMES);
              round_result <= RES_NONE;
              player_reset <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
